// File: rtl/alu_result_reg.sv
// Registered ALU result/flag stage: a 2-entry valid/ready FIFO with a condition-code evaluator
// on the head entry and a saturating counter of accepted overflow results.
module alu_result_reg #(
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] r_in,
    input  logic         c_in,
    input  logic         n_in,
    input  logic         v_in,
    input  logic         z_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [M-1:0] r_out,
    output logic         c_out,
    output logic         n_out,
    output logic         v_out,
    output logic         z_out,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic [3:0]   cond,
    output logic         cond_true,
    output logic [7:0]   ovf_cnt,
    input  logic         clr
);

    typedef struct packed {
        logic [M-1:0] r;
        logic         c;
        logic         n;
        logic         v;
        logic         z;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    entry_t     r_head;
    entry_t     r_tail;
    entry_t     w_in_entry;
    logic [7:0] r_ovf_cnt;
    logic       w_push;
    logic       w_pop;
    logic       w_head_ld;
    logic       w_head_from_tail;
    logic       w_tail_ld;
    logic       w_cond_raw;

    assign w_in_entry = '{r: r_in, c: c_in, n: n_in, v: v_in, z: z_in};

    assign in_ready  = (r_state != StTwo);
    assign out_valid = (r_state != StEmpty);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_head_ld        = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_ld        = 1'b0;
        case (r_state)
            StEmpty: begin
                if (w_push) begin
                    w_head_ld   = 1'b1;
                    w_state_nxt = StOne;
                end
            end
            StOne: begin
                // Push with pop: the new entry replaces the departing head directly.
                if (w_push && w_pop) begin
                    w_head_ld = 1'b1;
                end else if (w_push) begin
                    w_tail_ld   = 1'b1;
                    w_state_nxt = StTwo;
                end else if (w_pop) begin
                    w_state_nxt = StEmpty;
                end
            end
            StTwo: begin
                if (w_pop) begin
                    w_head_from_tail = 1'b1;
                    w_state_nxt      = StOne;
                end
            end
            default: w_state_nxt = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_head_ld) begin
                r_head <= w_in_entry;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end
            if (w_tail_ld) begin
                r_tail <= w_in_entry;
            end
        end
    end

    assign r_out = r_head.r;
    assign c_out = r_head.c;
    assign n_out = r_head.n;
    assign v_out = r_head.v;
    assign z_out = r_head.z;

    always_comb begin
        w_cond_raw = 1'b0;
        case (cond)
            4'h0: w_cond_raw = r_head.z;
            4'h1: w_cond_raw = !r_head.z;
            4'h2: w_cond_raw = r_head.c;
            4'h3: w_cond_raw = !r_head.c;
            4'h4: w_cond_raw = r_head.n;
            4'h5: w_cond_raw = !r_head.n;
            4'h6: w_cond_raw = r_head.v;
            4'h7: w_cond_raw = !r_head.v;
            4'h8: w_cond_raw = r_head.c && !r_head.z;
            4'h9: w_cond_raw = !r_head.c || r_head.z;
            4'hA: w_cond_raw = (r_head.n == r_head.v);
            4'hB: w_cond_raw = (r_head.n != r_head.v);
            4'hC: w_cond_raw = !r_head.z && (r_head.n == r_head.v);
            4'hD: w_cond_raw = r_head.z || (r_head.n != r_head.v);
            4'hE: w_cond_raw = 1'b1;
            default: w_cond_raw = 1'b0;
        endcase
    end

    assign cond_true = w_cond_raw && out_valid;

    // Clear wins over a same-cycle overflow push; the count saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= 8'd0;
        end else if (clr) begin
            r_ovf_cnt <= 8'd0;
        end else if (w_push && v_in && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_alu_result_reg.sv
// Self-checking bench for alu_result_reg: queue scoreboard for FIFO contents and overflow count,
// plus a constant table of condition-code vectors.
module tb_alu_result_reg;

    logic       clk;
    logic       rst;
    logic [3:0] r_in;
    logic       c_in, n_in, v_in, z_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] r_out;
    logic       c_out, n_out, v_out, z_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] cond;
    logic       cond_true;
    logic [7:0] ovf_cnt;
    logic       clr;

    alu_result_reg #(.M(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .r_in      (r_in),
        .c_in      (c_in),
        .n_in      (n_in),
        .v_in      (v_in),
        .z_in      (z_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_out     (r_out),
        .c_out     (c_out),
        .n_out     (n_out),
        .v_out     (v_out),
        .z_out     (z_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cond      (cond),
        .cond_true (cond_true),
        .ovf_cnt   (ovf_cnt),
        .clr       (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic       c, n, v, z;
    } entry_t;

    typedef struct {
        logic [3:0] r;
        logic       c, n, v, z;
        logic [3:0] cc;
        logic       exp;
    } cond_vec_t;

    entry_t     m_q[$];
    int         m_ovf;
    int         checks;
    int         failures;
    cond_vec_t  vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        if (m_q.size() > 0) begin
            chk("r_out", 32'(r_out), 32'(m_q[0].r));
            chk("flags", 32'({c_out, n_out, v_out, z_out}),
                32'({m_q[0].c, m_q[0].n, m_q[0].v, m_q[0].z}));
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the model advanced.
    task automatic cycle(input logic iv, input logic [3:0] r, input logic c, input logic n,
                         input logic v, input logic z, input logic ordy, input logic cl);
        bit     acc;
        bit     pop;
        entry_t e;
        in_valid  = iv;
        r_in      = r;
        c_in      = c;
        n_in      = n;
        v_in      = v;
        z_in      = z;
        out_ready = ordy;
        clr       = cl;
        @(negedge clk);
        check_outputs();
        acc = iv && (m_q.size() < 2);
        pop = ordy && (m_q.size() > 0);
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            e = '{r: r, c: c, n: n, v: v, z: z};
            m_q.push_back(e);
        end
        if (cl) m_ovf = 0;
        else if (acc && v && m_ovf < 255) m_ovf++;
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_ovf     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        r_in      = 4'h0;
        {c_in, n_in, v_in, z_in} = 4'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        cond      = 4'hE;

        //             r     c  n  v  z  cond exp
        vecs[0]  = '{4'hA, 1, 1, 0, 0, 4'h2, 1};
        vecs[1]  = '{4'hA, 1, 1, 0, 0, 4'h0, 0};
        vecs[2]  = '{4'h3, 0, 0, 0, 1, 4'h0, 1};
        vecs[3]  = '{4'h3, 0, 0, 0, 1, 4'h1, 0};
        vecs[4]  = '{4'h4, 0, 0, 0, 0, 4'h3, 1};
        vecs[5]  = '{4'h8, 0, 1, 0, 0, 4'h4, 1};
        vecs[6]  = '{4'h8, 0, 1, 0, 0, 4'h5, 0};
        vecs[7]  = '{4'h7, 0, 0, 1, 0, 4'h6, 1};
        vecs[8]  = '{4'h1, 0, 0, 0, 0, 4'h7, 1};
        vecs[9]  = '{4'h2, 1, 0, 0, 0, 4'h8, 1};
        vecs[10] = '{4'h2, 1, 0, 0, 1, 4'h8, 0};
        vecs[11] = '{4'h5, 0, 0, 0, 0, 4'h9, 1};
        vecs[12] = '{4'h5, 1, 0, 0, 0, 4'h9, 0};
        vecs[13] = '{4'h9, 0, 1, 0, 0, 4'hA, 0};
        vecs[14] = '{4'h9, 0, 1, 1, 0, 4'hA, 1};
        vecs[15] = '{4'h9, 0, 1, 0, 0, 4'hB, 1};
        vecs[16] = '{4'h9, 0, 1, 0, 0, 4'hC, 0};
        vecs[17] = '{4'h6, 0, 0, 0, 0, 4'hC, 1};
        vecs[18] = '{4'h9, 0, 1, 0, 0, 4'hD, 1};
        vecs[19] = '{4'h6, 0, 0, 0, 0, 4'hD, 0};
        vecs[20] = '{4'h9, 0, 1, 0, 0, 4'hE, 1};
        vecs[21] = '{4'h9, 0, 1, 0, 0, 4'hF, 0};

        // Reset values while rst is held
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("rst_r_out", 32'(r_out), 32'd0);
        chk("rst_flags", 32'({c_out, n_out, v_out, z_out}), 32'd0);
        chk("rst_cond_true", 32'(cond_true), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Condition-code table: load one entry, evaluate, pop it
        for (int i = 0; i < 22; i++) begin
            cycle(1, vecs[i].r, vecs[i].c, vecs[i].n, vecs[i].v, vecs[i].z, 0, 0);
            cond = vecs[i].cc;
            #1;
            chk($sformatf("cond_%0d", i), 32'(cond_true), 32'(vecs[i].exp));
            cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);
        end
        cond = 4'hE;
        #1;
        chk("cond_empty", 32'(cond_true), 32'd0);

        // Fill, backpressure, drain in order
        cycle(1, 4'h1, 0, 0, 0, 0, 0, 0);
        cycle(1, 4'h2, 0, 0, 0, 0, 0, 0);
        cycle(1, 4'h3, 0, 0, 0, 0, 0, 0);
        cycle(1, 4'h3, 0, 0, 0, 0, 1, 0);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);

        // Push+pop in ONE replaces the head
        cycle(1, 4'h5, 0, 0, 0, 0, 0, 0);
        cycle(1, 4'h6, 0, 0, 0, 0, 1, 0);
        cycle(0, 4'h0, 0, 0, 0, 0, 0, 0);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);

        // Saturating overflow count, then clear beats a counted push
        for (int i = 0; i < 300; i++) begin
            cycle(1, 4'(i), 0, 0, 1, 0, 1, 0);
        end
        chk("ovf_saturated", 32'(ovf_cnt), 32'd255);
        cycle(1, 4'hC, 0, 0, 1, 0, 1, 1);
        chk("ovf_clr_prio", 32'(ovf_cnt), 32'd0);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset from TWO with ovf_cnt=3
        cycle(1, 4'hB, 0, 0, 1, 0, 0, 0);
        cycle(1, 4'hC, 0, 0, 1, 0, 1, 0);
        cycle(1, 4'hD, 1, 1, 1, 1, 0, 0);
        check_outputs();
        out_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("arst_r_out", 32'(r_out), 32'd0);
        chk("arst_cond_true", 32'(cond_true), 32'd0);
        m_q.delete();
        m_ovf = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 4'h7, 0, 0, 1, 0, 0, 0);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);
        cycle(0, 4'h0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_reg.md
ALU_RESULT_REG -- requirements
Module: alu_result_reg

Interface
REQ-001 SHALL have parameter M, default 4, the result width matching the ALU operand width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-004 SHALL have port r_in, input, M, the ALU result.
REQ-005 SHALL have ports c_in, n_in, v_in, z_in, input, 1 each, the ALU carry, negative, overflow and zero flags.
REQ-006 SHALL have port in_valid, input, 1, meaning the producer offers r_in/flags this cycle.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept an entry this cycle.
REQ-008 SHALL have port r_out, output, M, the head-entry result.
REQ-009 SHALL have ports c_out, n_out, v_out, z_out, output, 1 each, the head-entry flags.
REQ-010 SHALL have port out_valid, output, 1, meaning the head entry is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the head entry this cycle.
REQ-012 SHALL have port cond, input, 4, the condition code to evaluate.
REQ-013 SHALL have port cond_true, output, 1, the condition result on the head flags.
REQ-014 SHALL have port ovf_cnt, output, 8, the count of accepted entries with V=1.
REQ-015 SHALL have port clr, input, 1, the synchronous clear of ovf_cnt.

Function
REQ-016 SHALL store entries of {r, c, n, v, z} in a 2-entry FIFO with states EMPTY, ONE and TWO.
REQ-017 SHALL accept an entry when in_valid && in_ready, and SHALL complete a pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (state != TWO) and out_valid = (state != EMPTY), both as registered-state decodes.
REQ-019 SHALL make the latency 1 cycle: an entry accepted at edge k appears on r_out/flags with out_valid=1 after edge k when the FIFO was EMPTY.
REQ-020 SHALL use these transitions: EMPTY+push -> ONE; ONE+push only -> TWO; ONE+pop only -> EMPTY; ONE+push+pop -> ONE, with the new entry becoming head; TWO+pop -> ONE, with the second entry becoming head.
REQ-021 SHALL ignore a push while in TWO, since in_ready=0, with no data corruption.
REQ-022 SHALL have no effect from out_ready while EMPTY.
REQ-023 SHALL preserve FIFO order; no entry is lost or duplicated.
REQ-024 SHALL hold r_out/flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL compute cond_true combinationally from the head flags, and SHALL force it to 0 when out_valid=0.
REQ-026 SHALL decode cond as: 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V; 8 C&!Z; 9 !C|Z; A N==V; B N!=V; C !Z&(N==V); D Z|(N!=V); E 1; F 0.
REQ-027 SHALL increment ovf_cnt on each accepted push with v_in=1, saturating at 255 with no wrap-around.
REQ-028 SHALL give clr priority over increment: clr and an overflow push in the same cycle -> ovf_cnt=0.
REQ-029 SHALL NOT count a rejected push (in_ready=0) in ovf_cnt.

Reset
REQ-030 SHALL, on rst=1 and regardless of clk, immediately force state EMPTY, out_valid=0, in_ready=1, ovf_cnt=0, r_out=0, all flag outputs 0 and cond_true=0.
REQ-031 SHALL discard all stored entries when rst asserts mid-operation; no pop completes in that cycle.
REQ-032 SHALL resume accepting pushes on the first rising edge after rst deasserts.

Verification
REQ-033 SHALL cover single transfer: push r_in=4'hA, c=1, n=1, v=0, z=0, out_ready=0 -> next cycle out_valid=1, r_out=4'hA; cond=2 -> cond_true=1; cond=0 -> cond_true=0.
REQ-034 SHALL cover fill and backpressure: push 4'h1 then 4'h2 with out_ready=0 -> in_ready=0; offer 4'h3 -> rejected; then pop twice -> 4'h1 then 4'h2, then out_valid=0.
REQ-035 SHALL cover simultaneous push/pop in ONE: head 4'h5, push 4'h6 with out_ready=1 -> state stays ONE, r_out=4'h6.
REQ-036 SHALL cover condition table: head n=1, v=0, z=0 -> cond A=0, B=1, C=0, D=1, E=1, F=0.
REQ-037 SHALL cover overflow counter: 300 pushes with v_in=1 and out_ready=1 -> ovf_cnt=255; clr together with a push where v_in=1 -> 0.
REQ-038 SHALL cover reset mid-operation: state TWO with ovf_cnt=3, assert rst between clock edges -> out_valid=0, in_ready=1 and ovf_cnt=0 immediately.
